// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
//
// Round-robin arbiter sharing one NoC output channel between N requesters.
// Packets are granted atomically: once a requester wins, it owns the channel
// from its first beat until its tail beat has been accepted. A one-entry
// registered output stage drives the shared channel.
//
// Optional feature macro: NOC_ARB_WATCHDOG_EN
//   When defined, a watchdog releases the grant of an owner that stops sending
//   beats mid-packet for TIMEOUT cycles, and raises a sticky err_timeout.
//   When undefined, err_timeout is tied 0 and a starving owner keeps the grant.
//
// Parameters:
//   N        number of requesters (2..8)
//   WIDTH    data bits per beat
//   TIMEOUT  watchdog limit in cycles (>= 2, watchdog build only)
//
// Ports:
//   CLK          clock, rising edge
//   _RESET       asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_data     per-requester beat data, requester i at [i*WIDTH +: WIDTH]
//   req_tail     per-requester last-beat marker
//   req_ready    per-requester beat accepted (combinational from state)
//   out_valid    shared channel beat valid (registered)
//   out_data     shared channel data (registered)
//   out_tail     shared channel last-beat marker (registered)
//   out_src      requester index owning the beat (registered)
//   out_ready    downstream accepts the beat
//   busy         arbiter holds a grant (LOCKED)
//   err_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
module noc_port_arbiter #(
   parameter int N       = 2,
   parameter int WIDTH   = 9,
   parameter int TIMEOUT = 64
) (
   input  logic                 CLK,
   input  logic                 _RESET,
   input  logic [N-1:0]         req_valid,
   input  logic [N*WIDTH-1:0]   req_data,
   input  logic [N-1:0]         req_tail,
   output logic [N-1:0]         req_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_tail,
   output logic [$clog2(N)-1:0] out_src,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int SW = $clog2(N);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    ptr_q, ptr_d;
   logic [SW-1:0]    owner_q, owner_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_tail_q, out_tail_d;
   logic [SW-1:0]    out_src_q, out_src_d;

`ifdef NOC_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    wd_cnt_q, wd_cnt_d;
   logic             err_timeout_q, err_timeout_d;
`else
   // TIMEOUT only matters in the watchdog build.
   logic             unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT >= 2);
`endif

   logic [SW-1:0]    winner_s;
   logic             any_valid_s;
   logic [SW-1:0]    owner_next_s;
   logic             own_valid_s;
   logic             own_tail_s;
   logic [WIDTH-1:0] own_data_s;
   logic             owner_ready_s;
   logic             accept_s;

   // Winner: first valid requester at or above ptr; if none, wrap to the lowest valid one.
   always_comb begin
      logic [SW-1:0] hi_idx;
      logic [SW-1:0] lo_idx;
      logic          hi_found;
      hi_idx   = ptr_q;
      lo_idx   = ptr_q;
      hi_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         lo_idx   = req_valid[i] ? SW'(i) : lo_idx;
         hi_idx   = (req_valid[i] && (SW'(i) >= ptr_q)) ? SW'(i) : hi_idx;
         hi_found = hi_found | (req_valid[i] && (SW'(i) >= ptr_q));
      end
      winner_s    = hi_found ? hi_idx : lo_idx;
      any_valid_s = |req_valid;
   end

   // Select the current owner's request signals.
   always_comb begin
      own_valid_s = 1'b0;
      own_tail_s  = 1'b0;
      own_data_s  = '0;
      for (int i = 0; i < N; i++) begin
         own_valid_s = (SW'(i) == owner_q) ? req_valid[i]              : own_valid_s;
         own_tail_s  = (SW'(i) == owner_q) ? req_tail[i]               : own_tail_s;
         own_data_s  = (SW'(i) == owner_q) ? req_data[i*WIDTH +: WIDTH] : own_data_s;
      end
   end

   assign owner_next_s  = (owner_q == SW'(N - 1)) ? '0 : owner_q + 1'b1;
   // The output stage can take a beat when empty or draining this cycle.
   assign owner_ready_s = (state_q == ST_LOCKED) && (!out_valid_q || out_ready);
   assign accept_s      = owner_ready_s && own_valid_s;

   // Only the owner sees ready, and only while LOCKED.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N; i++) begin
         req_ready[i] = (SW'(i) == owner_q) && owner_ready_s;
      end
   end

   // Next-state: grant FSM, output register and optional watchdog.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_tail_d  = out_tail_q;
      out_src_d   = out_src_q;
`ifdef NOC_ARB_WATCHDOG_EN
      wd_cnt_d      = wd_cnt_q;
      err_timeout_d = err_timeout_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (any_valid_s) begin
               state_d = ST_LOCKED;
               owner_d = winner_s;
            end else begin
               state_d = ST_IDLE;
            end
`ifdef NOC_ARB_WATCHDOG_EN
            wd_cnt_d = '0;
`endif
         end
         ST_LOCKED: begin
            if (accept_s && own_tail_s) begin
               state_d = ST_IDLE;
               ptr_d   = owner_next_s;
            end else begin
               state_d = ST_LOCKED;
            end
`ifdef NOC_ARB_WATCHDOG_EN
            // Count only cycles where the owner could send but does not.
            if (accept_s) begin
               wd_cnt_d = '0;
            end else if (owner_ready_s && !own_valid_s) begin
               if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                  state_d       = ST_IDLE;
                  ptr_d         = owner_next_s;
                  err_timeout_d = 1'b1;
                  wd_cnt_d      = '0;
               end else begin
                  wd_cnt_d = wd_cnt_q + 1'b1;
               end
            end else begin
               wd_cnt_d = wd_cnt_q;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new beat overrides the drain, so back-to-back beats keep out_valid high.
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = own_data_s;
         out_tail_d  = own_tail_s;
         out_src_d   = owner_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers; _RESET clears everything without waiting for an edge.
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tail_q  <= 1'b0;
         out_src_q   <= '0;
`ifdef NOC_ARB_WATCHDOG_EN
         wd_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tail_q  <= out_tail_d;
         out_src_q   <= out_src_d;
`ifdef NOC_ARB_WATCHDOG_EN
         wd_cnt_q      <= wd_cnt_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tail  = out_tail_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q == ST_LOCKED);
`ifdef NOC_ARB_WATCHDOG_EN
   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule
